dma_mem_arbiter: RTL

DMA_MEM_ARBITER -- requirements
Module: dma_mem_arbiter

---
 rtl/dma_mem_arbiter.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/dma_mem_arbiter.sv
// Two-master memory port arbiter (core M0, DMAC M1) with burst-limited round-robin ownership.
// Define ARB_CORE_PRIORITY_EN to give M0 strict priority: it wins ties and is never preempted.
module dma_mem_arbiter #(
    parameter int unsigned ADR_SIZE  = 16,
    parameter int unsigned DATA_SIZE = 16,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 m0_req,
    input  logic                 m0_wr_rd,
    input  logic [ADR_SIZE-1:0]  m0_adr,
    input  logic [DATA_SIZE-1:0] m0_wdata,
    input  logic                 m1_req,
    input  logic                 m1_wr_rd,
    input  logic [ADR_SIZE-1:0]  m1_adr,
    input  logic [DATA_SIZE-1:0] m1_wdata,
    output logic                 m0_gnt,
    output logic                 m1_gnt,
    output logic                 m0_rvalid,
    output logic                 m1_rvalid,
    output logic [DATA_SIZE-1:0] rdata,
    output logic                 mem_en,
    output logic                 mem_wr_rd,
    output logic [ADR_SIZE-1:0]  mem_adr,
    output logic [DATA_SIZE-1:0] mem_dout,
    input  logic [DATA_SIZE-1:0] mem_din,
    input  logic                 mem_stall
);

    localparam logic [7:0] BURST_LAST = 8'(MAX_BURST);
`ifdef ARB_CORE_PRIORITY_EN
    localparam bit CORE_PRIO = 1'b1;
`else
    localparam bit CORE_PRIO = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       last_served_q, last_served_d;
    logic       rvalid0_q, rvalid0_d;
    logic       rvalid1_q, rvalid1_d;
    logic       beat_c;
    logic       burst_end_c;
    logic [7:0] cnt_inc_c;

    // Memory port follows the current owner; nothing is driven while idle.
    always_comb begin
        mem_en    = 1'b0;
        mem_wr_rd = 1'b0;
        mem_adr   = '0;
        mem_dout  = '0;
        case (state_q)
            OWN0: begin
                mem_en    = m0_req;
                mem_wr_rd = m0_wr_rd;
                mem_adr   = m0_adr;
                mem_dout  = m0_wdata;
            end
            OWN1: begin
                mem_en    = m1_req;
                mem_wr_rd = m1_wr_rd;
                mem_adr   = m1_adr;
                mem_dout  = m1_wdata;
            end
            default: ;
        endcase
    end

    assign beat_c      = mem_en && !mem_stall;
    assign cnt_inc_c   = cnt_q + 8'd1;
    assign burst_end_c = beat_c && (cnt_inc_c == BURST_LAST);

    // Ownership FSM, beat counter and read-valid routing.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        last_served_d = last_served_q;
        rvalid0_d     = beat_c && (state_q == OWN0) && !mem_wr_rd;
        rvalid1_d     = beat_c && (state_q == OWN1) && !mem_wr_rd;
        case (state_q)
            IDLE: begin
                if (m0_req && (!m1_req || CORE_PRIO || last_served_q)) begin
                    state_d       = OWN0;
                    cnt_d         = 8'd0;
                    last_served_d = 1'b0;
                end else if (m1_req) begin
                    state_d       = OWN1;
                    cnt_d         = 8'd0;
                    last_served_d = 1'b1;
                end
            end
            OWN0: begin
                if (!m0_req) begin
                    state_d = IDLE;
                end else if (burst_end_c) begin
                    cnt_d = 8'd0;
                    if (m1_req && !CORE_PRIO) begin
                        state_d       = OWN1;
                        last_served_d = 1'b1;
                    end
                end else if (beat_c) begin
                    cnt_d = cnt_inc_c;
                end
            end
            OWN1: begin
                if (!m1_req) begin
                    state_d = IDLE;
                end else if (burst_end_c) begin
                    cnt_d = 8'd0;
                    if (m0_req) begin
                        state_d       = OWN0;
                        last_served_d = 1'b0;
                    end
                end else if (beat_c) begin
                    cnt_d = cnt_inc_c;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= 8'd0;
            last_served_q <= 1'b1;
            rvalid0_q     <= 1'b0;
            rvalid1_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            last_served_q <= last_served_d;
            rvalid0_q     <= rvalid0_d;
            rvalid1_q     <= rvalid1_d;
        end
    end

    assign m0_gnt    = (state_q == OWN0);
    assign m1_gnt    = (state_q == OWN1);
    assign m0_rvalid = rvalid0_q;
    assign m1_rvalid = rvalid1_q;
    assign rdata     = mem_din;

endmodule
